// File: rtl/pwm_cmd_pkg.sv
// Shared opcodes, FSM states and shadow-target selector for the PWM command loader.
// Build option PWM_CMD_FADE_EN (see pwm_cmd_loader) does not affect this package.
package pwm_cmd_pkg;

    localparam int unsigned OP_W = 8;

    localparam logic [OP_W-1:0] OP_CLR_ERR = 8'h00;
    localparam logic [OP_W-1:0] OP_DUTY    = 8'h01;
    localparam logic [OP_W-1:0] OP_MAX     = 8'h02;
    localparam logic [OP_W-1:0] OP_COMMIT  = 8'h03;

    typedef enum logic {
        IDLE,
        WAIT_DATA
    } state_e;

    typedef enum logic {
        TGT_DUTY,
        TGT_MAX
    } tgt_e;

endpackage

// File: rtl/strobe_sync.sv
// Brings the Arduino write strobe into the clk domain and flags each rising edge.
// rise_c is high for exactly one cycle, two edges after the strobe is first sampled high.
module strobe_sync (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic rise_c
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = strobe;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise_c = sync2_q & ~prev_q;

endmodule

// File: rtl/pwm_cmd_loader.sv
// Byte-wide command receiver feeding pwm_module; commits shadow duty/max only at a period boundary.
// Define PWM_CMD_FADE_EN to slew duty by one step per period toward the committed value.
module pwm_cmd_loader
    import pwm_cmd_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             strobe,
    input  logic             period_end,
    output logic [WIDTH-1:0] duty,
    output logic [WIDTH-1:0] max_value,
    output logic             busy,
    output logic             err
);

    localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic rise_c;

    state_e           state_q,       state_d;
    tgt_e             tgt_q,         tgt_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [WIDTH-1:0] shadow_duty_q, shadow_duty_d;
    logic [WIDTH-1:0] shadow_max_q,  shadow_max_d;
    logic             pending_q,     pending_d;
    logic [WIDTH-1:0] duty_q,        duty_d;
    logic [WIDTH-1:0] max_q,         max_d;
    logic             busy_q,        busy_d;
    logic             err_q,         err_d;
`ifdef PWM_CMD_FADE_EN
    logic [WIDTH-1:0] target_q,      target_d;
`endif

    strobe_sync u_strobe_sync (
        .clk    (clk),
        .rst    (rst),
        .strobe (strobe),
        .rise_c (rise_c)
    );

    // Commit first (uses pre-edge shadows), then byte handling so a same-edge arm stays pending.
    always_comb begin
        state_d       = state_q;
        tgt_d         = tgt_q;
        cnt_d         = cnt_q;
        shadow_duty_d = shadow_duty_q;
        shadow_max_d  = shadow_max_q;
        pending_d     = pending_q;
        duty_d        = duty_q;
        max_d         = max_q;
        busy_d        = busy_q;
        err_d         = err_q;
`ifdef PWM_CMD_FADE_EN
        target_d      = target_q;
`endif

        if (period_end && pending_q) begin
            pending_d = 1'b0;
            max_d     = shadow_max_q;
`ifdef PWM_CMD_FADE_EN
            target_d  = shadow_duty_q;
`else
            duty_d    = shadow_duty_q;
`endif
        end
`ifdef PWM_CMD_FADE_EN
        else if (period_end && (duty_q != target_q)) begin
            duty_d = (duty_q < target_q) ? duty_q + WIDTH'(1) : duty_q - WIDTH'(1);
        end
`endif

        case (state_q)
            IDLE: begin
                if (rise_c) begin
                    case (data_in)
                        WIDTH'(OP_CLR_ERR): err_d = 1'b0;
                        WIDTH'(OP_DUTY): begin
                            state_d = WAIT_DATA;
                            tgt_d   = TGT_DUTY;
                            cnt_d   = '0;
                            busy_d  = 1'b1;
                        end
                        WIDTH'(OP_MAX): begin
                            state_d = WAIT_DATA;
                            tgt_d   = TGT_MAX;
                            cnt_d   = '0;
                            busy_d  = 1'b1;
                        end
                        WIDTH'(OP_COMMIT): pending_d = 1'b1;
                        default:           err_d     = 1'b1;
                    endcase
                end
            end
            WAIT_DATA: begin
                if (rise_c) begin
                    if (tgt_q == TGT_DUTY) begin
                        shadow_duty_d = data_in;
                    end else begin
                        shadow_max_d = data_in;
                    end
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            tgt_q         <= TGT_DUTY;
            cnt_q         <= '0;
            shadow_duty_q <= '0;
            shadow_max_q  <= '1;
            pending_q     <= 1'b0;
            duty_q        <= '0;
            max_q         <= '1;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
`ifdef PWM_CMD_FADE_EN
            target_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            tgt_q         <= tgt_d;
            cnt_q         <= cnt_d;
            shadow_duty_q <= shadow_duty_d;
            shadow_max_q  <= shadow_max_d;
            pending_q     <= pending_d;
            duty_q        <= duty_d;
            max_q         <= max_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
`ifdef PWM_CMD_FADE_EN
            target_q      <= target_d;
`endif
        end
    end

    assign duty      = duty_q;
    assign max_value = max_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
